// File: rtl/ysyx_23060025_lsu.sv
// Load/store unit: takes one op from execute, performs at most one bus access,
// and holds the write-back result until it is consumed.
module ysyx_23060025_lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                exu_valid_i,
  output logic                lsu_ready_o,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wmask_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [DATA_LEN-1:0] wb_data_o,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic                lsu_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] st,
                                         input logic [1:0] a);
    logic half_bad;
    logic word_bad;
    half_bad = ((lt == LD_LH) || (lt == LD_LHU) || (st == ST_SH)) && a[0];
    word_bad = ((lt == LD_LW) || (st == ST_SW)) && (a != 2'b00);
    return half_bad || word_bad;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] st, input logic [1:0] a);
    case (st)
      ST_SB:   return 4'b0001 << a;
      ST_SH:   return 4'b0011 << a;
      ST_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_LEN-1:0] store_lanes(input logic [1:0] st,
                                                      input logic [DATA_LEN-1:0] w);
    case (st)
      ST_SB:   return {4{w[7:0]}};
      ST_SH:   return {2{w[15:0]}};
      ST_SW:   return w;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_LEN-1:0] load_extend(input logic [2:0] lt, input logic [1:0] a,
                                                      input logic [DATA_LEN-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (lt)
      LD_LB:   return {{(DATA_LEN-8){b[7]}}, b};
      LD_LBU:  return {{(DATA_LEN-8){1'b0}}, b};
      LD_LH:   return {{(DATA_LEN-16){h[15]}}, h};
      LD_LHU:  return {{(DATA_LEN-16){1'b0}}, h};
      LD_LW:   return rd;
      default: return '0;
    endcase
  endfunction

  state_t state, state_nxt;

  logic                accept;
  logic [2:0]          load_eff;
  logic                misal;

  logic [DATA_LEN-1:0] addr_p0;
  logic [DATA_LEN-1:0] wdata_p0;
  logic [2:0]          load_p0;
  logic [1:0]          store_p0;
  logic                wd_p0;
  logic [4:0]          wreg_p0;
  logic                err_p0;
  logic [DATA_LEN-1:0] rdata_p1;

  // Stores win over loads; reserved load encodings collapse to none.
  assign accept   = (state == IDLE) && exu_valid_i;
  assign load_eff = ((store_type_i != ST_NONE) || (load_type_i > LD_LW)) ? LD_NONE : load_type_i;
  assign misal    = is_misaligned(load_eff, store_type_i, addr_i[1:0]);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: operands captured on accept
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0  <= addr_i;
      wdata_p0 <= wdata_i;
      load_p0  <= load_eff;
      store_p0 <= store_type_i;
      wd_p0    <= wd_i;
      wreg_p0  <= wreg_i;
      err_p0   <= misal;
    end
  end

  // Stage p1: bus response word
  always_ff @(posedge clock) begin
    if ((state == WAIT_RSP) && mem_rvalid_i) rdata_p1 <= mem_rdata_i;
  end

  // Outputs are decoded from the state, so everything reads zero outside its phase.
  always_comb begin
    state_nxt   = state;
    lsu_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = 4'b0000;
    wb_valid_o  = 1'b0;
    wb_data_o   = '0;
    wd_o        = 1'b0;
    wreg_o      = 5'd0;
    lsu_err_o   = 1'b0;
    case (state)
      IDLE: begin
        lsu_ready_o = 1'b1;
        if (exu_valid_i) begin
          if (misal)                                               state_nxt = DONE;
          else if ((store_type_i != ST_NONE) || (load_eff != LD_NONE)) state_nxt = REQ;
          else                                                     state_nxt = DONE;
        end
      end
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = (store_p0 != ST_NONE);
        mem_addr_o  = {addr_p0[DATA_LEN-1:2], 2'b00};
        mem_wdata_o = store_lanes(store_p0, wdata_p0);
        mem_wmask_o = store_mask(store_p0, addr_p0[1:0]);
        if (mem_ready_i) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) state_nxt = DONE;
      end
      DONE: begin
        wb_valid_o = 1'b1;
        wreg_o     = wreg_p0;
        lsu_err_o  = err_p0;
        wd_o       = err_p0 ? 1'b0 : wd_p0;
        if (err_p0 || (store_p0 != ST_NONE)) wb_data_o = '0;
        else if (load_p0 != LD_NONE)         wb_data_o = load_extend(load_p0, addr_p0[1:0], rdata_p1);
        else                                 wb_data_o = addr_p0;
        if (wb_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_lsu.sv
// Table-driven scoreboard bench for the LSU plus hand-written reset sequences.
module tb_ysyx_23060025_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        exu_valid_i;
  logic        lsu_ready_o;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic        lsu_err_o;

  ysyx_23060025_lsu #(.DATA_LEN(32)) dut (
    .clock(clock), .reset(reset),
    .exu_valid_i(exu_valid_i), .lsu_ready_o(lsu_ready_o),
    .addr_i(addr_i), .wdata_i(wdata_i), .load_type_i(load_type_i),
    .store_type_i(store_type_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .lsu_err_o(lsu_err_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic        wd;
    logic [4:0]  wreg;
    int          rdy_dly;
    int          wb_dly;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wb;
    logic        exp_wd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exu_valid_i  = 1'b0;
    addr_i       = 32'hFFFF_FFFF;
    wdata_i      = $urandom;
    load_type_i  = 3'd0;
    store_type_i = 2'd0;
    wd_i         = 1'b0;
    wreg_i       = 5'd0;
  endtask

  task automatic run_op(input vec_t v);
    vec_t e;
    int   cyc;
    int   req_cyc;
    int   hs;
    int   wb_cyc;
    bit   rsp_pend;
    bit   done;
    bit   seen_wb;
    e = v;
    @(negedge clock);
    check("ready_before", {31'd0, lsu_ready_o}, 32'd1);
    exu_valid_i  = 1'b1;
    addr_i       = v.addr;
    wdata_i      = v.wdata;
    load_type_i  = v.lt;
    store_type_i = v.st;
    wd_i         = v.wd;
    wreg_i       = v.wreg;
    sb_q.push_back(v);
    @(negedge clock);
    idle_inputs();
    cyc = 1; req_cyc = 0; hs = 0; wb_cyc = 0;
    rsp_pend = 0; done = 0; seen_wb = 0;
    while (!done && cyc < 60) begin
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'hBAD0_BAD0;
      wb_ready_i   = 1'b0;
      if (mem_req_o) begin
        req_cyc++;
        check("mem_we", {31'd0, mem_we_o}, {31'd0, v.exp_we});
        check("mem_addr", mem_addr_o, v.exp_maddr);
        check("mem_wmask", {28'd0, mem_wmask_o}, {28'd0, v.exp_mask});
        if (v.exp_we) check("mem_wdata", mem_wdata_o, v.exp_mwdata);
        if (req_cyc > v.rdy_dly) begin
          mem_ready_i = 1'b1;
          hs++;
          rsp_pend = 1;
        end
      end else if (rsp_pend) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = v.rdata;
        rsp_pend     = 0;
      end
      if (wb_valid_o) begin
        if (!seen_wb) begin
          seen_wb = 1;
          check("latency", cyc, v.exp_lat);
          n_checks++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got wb_valid expected no pending op");
          end else e = sb_q.pop_front();
        end
        check("wb_data", wb_data_o, e.exp_wb);
        check("wd_o", {31'd0, wd_o}, {31'd0, e.exp_wd});
        check("wreg_o", {27'd0, wreg_o}, {27'd0, e.wreg});
        check("lsu_err", {31'd0, lsu_err_o}, {31'd0, e.exp_err});
        check("ready_busy", {31'd0, lsu_ready_o}, 32'd0);
        wb_cyc++;
        if (wb_cyc > v.wb_dly) begin
          wb_ready_i = 1'b1;
          done = 1;
        end
      end
      @(negedge clock);
      cyc++;
    end
    wb_ready_i   = 1'b0;
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout: got no wb handshake expected one within 60 cycles");
    end
    check("req_count", hs, {31'd0, v.exp_req});
    check("ready_after", {31'd0, lsu_ready_o}, 32'd1);
    check("wb_valid_after", {31'd0, wb_valid_o}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {31'd0, lsu_ready_o}, 32'd1);
    check({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
    check({tag, "_wb_valid"}, {31'd0, wb_valid_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    //            addr          wdata         rdata         lt    st    wd    wreg  rdy wb req   we    maddr         mwdata        mask   wb            wd    err   lat
    vecs[0]  = '{32'h8000_0004, 32'hDEADBEEF, 32'h0,        3'd0, 2'd3, 1'b0, 5'd0,  0, 0, 1'b1, 1'b1, 32'h8000_0004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0, 3};
    vecs[1]  = '{32'h8000_0003, 32'h0,        32'h80FF_1234, 3'd1, 2'd0, 1'b1, 5'd10, 0, 0, 1'b1, 1'b0, 32'h8000_0000, 32'h0,        4'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 3};
    vecs[2]  = '{32'h8000_0003, 32'h0,        32'h80FF_1234, 3'd2, 2'd0, 1'b1, 5'd11, 0, 0, 1'b1, 1'b0, 32'h8000_0000, 32'h0,        4'h0, 32'h0000_0080, 1'b1, 1'b0, 3};
    vecs[3]  = '{32'h0000_0102, 32'h0000_ABCD, 32'h0,        3'd0, 2'd2, 1'b0, 5'd0,  4, 0, 1'b1, 1'b1, 32'h0000_0100, 32'hABCD_ABCD, 4'hC, 32'h0,        1'b0, 1'b0, 7};
    vecs[4]  = '{32'h0000_0101, 32'h0,        32'h0,        3'd5, 2'd0, 1'b1, 5'd3,  0, 0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 1};
    vecs[5]  = '{32'h0000_1234, 32'h0,        32'h0,        3'd0, 2'd0, 1'b1, 5'd5,  0, 3, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_1234, 1'b1, 1'b0, 1};
    vecs[6]  = '{32'h0000_0002, 32'h0,        32'h8001_7FFF, 3'd3, 2'd0, 1'b1, 5'd4,  0, 0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'hFFFF_8001, 1'b1, 1'b0, 3};
    vecs[7]  = '{32'h0000_0000, 32'h0,        32'h8001_F00D, 3'd4, 2'd0, 1'b1, 5'd6,  0, 1, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_F00D, 1'b1, 1'b0, 3};
    vecs[8]  = '{32'h0000_0010, 32'h0,        32'h1234_5678, 3'd5, 2'd0, 1'b1, 5'd31, 0, 0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'h1234_5678, 1'b1, 1'b0, 3};
    vecs[9]  = '{32'h0000_0201, 32'h0000_00A5, 32'h0,        3'd0, 2'd1, 1'b0, 5'd0,  1, 0, 1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'h2, 32'h0,        1'b0, 1'b0, 4};
    vecs[10] = '{32'h0000_0300, 32'h1122_3344, 32'h0,        3'd5, 2'd3, 1'b0, 5'd0,  0, 0, 1'b1, 1'b1, 32'h0000_0300, 32'h1122_3344, 4'hF, 32'h0,        1'b0, 1'b0, 3};
    vecs[11] = '{32'h0000_0001, 32'h0,        32'h0000_7F00, 3'd1, 2'd0, 1'b1, 5'd8,  0, 0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_007F, 1'b1, 1'b0, 3};
    vecs[12] = '{32'h0000_0103, 32'h0000_1234, 32'h0,        3'd0, 2'd2, 1'b0, 5'd0,  0, 0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 1};
    vecs[13] = '{32'h0000_0055, 32'h0,        32'h0,        3'd6, 2'd0, 1'b1, 5'd7,  0, 0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0000_0055, 1'b1, 1'b0, 1};
    vecs[14] = '{32'h0000_0002, 32'h0,        32'h00FE_0000, 3'd1, 2'd0, 1'b1, 5'd9,  0, 0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 32'hFFFF_FFFE, 1'b1, 1'b0, 3};
    vecs[15] = '{32'h0000_0002, 32'h0000_FFFF, 32'h0,        3'd0, 2'd3, 1'b1, 5'd12, 0, 0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 1};

    reset = 1'b1;
    idle_inputs();
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; wb_ready_i = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'd0, lsu_ready_o}, 32'd1);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    check("rst_mwdata", mem_wdata_o, 32'd0);
    check("rst_mask", {28'd0, mem_wmask_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_wd", {31'd0, wd_o}, 32'd0);
    check("rst_wreg", {27'd0, wreg_o}, 32'd0);
    check("rst_err", {31'd0, lsu_err_o}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // Reset while waiting for the response, then a stray response.
    @(negedge clock);
    exu_valid_i = 1'b1; addr_i = 32'h40; load_type_i = 3'd5; wd_i = 1'b1; wreg_i = 5'd2;
    @(negedge clock);
    idle_inputs();
    check("rw_req", {31'd0, mem_req_o}, 32'd1);
    mem_ready_i = 1'b1;
    @(negedge clock);
    mem_ready_i = 1'b0;
    check("rw_wait_req", {31'd0, mem_req_o}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    check_quiet("rw_reset");
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      mem_rvalid_i = 1'b0;
      check_quiet("rw_after");
    end

    // Reset while the request is outstanding.
    exu_valid_i = 1'b1; addr_i = 32'h80; store_type_i = 2'd3; wdata_i = 32'h5555_AAAA;
    @(negedge clock);
    idle_inputs();
    check("rq_req", {31'd0, mem_req_o}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_quiet("rq_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_quiet("rq_after");
    end

    run_op(vecs[0]);
    run_op(vecs[5]);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_lsu.md
YSYX_23060025_LSU -- requirements
Module: ysyx_23060025_LSU

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, datapath width.
REQ-002 SHALL have ports, in this order:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- exu_valid_i  in  1  execute stage offers an op
- lsu_ready_o  out  1  LSU can accept an op
- addr_i  in  32  ALU result: effective address, or pass-through result
- wdata_i  in  32  store data (rs2)
- load_type_i  in  3  load kind
- store_type_i  in  2  store kind
- wd_i  in  1  register write enable
- wreg_i  in  5  destination register
- mem_req_o  out  1  bus request valid
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word-aligned address
- mem_wdata_o  out  32  lane-replicated store data
- mem_wmask_o  out  4  byte strobes
- mem_ready_i  in  1  bus accepts request
- mem_rvalid_i  in  1  bus response, for both reads and writes
- mem_rdata_i  in  32  read data word
- wb_valid_o  out  1  result valid to write-back
- wb_ready_i  in  1  write-back accepts
- wb_data_o  out  32  write-back data
- wd_o  out  1  registered write enable
- wreg_o  out  5  registered destination
- lsu_err_o  out  1  misaligned access flag, valid with wb_valid_o
REQ-003 SHALL decode store_type as 00 none, 01 SB, 10 SH, 11 SW.
REQ-004 SHALL decode load_type as 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110 and 111 SHALL be treated as none.

Function
REQ-005 SHALL implement FSM states IDLE, REQ, WAIT_RSP, DONE; lsu_ready_o = (state == IDLE).
REQ-006 IDLE: on exu_valid_i=1, SHALL register addr, wdata, types, wd and wreg, then move to:
- REQ for a load or store
- DONE with lsu_err_o=1 for a misaligned access
- DONE for neither (pass-through)
REQ-007 Misaligned means any of: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00.
REQ-008 If load_type and store_type are both non-none, the store SHALL take precedence and the load SHALL be ignored.
REQ-009 REQ: mem_req_o=1. mem_we_o, mem_addr_o={addr[31:2],2'b00}, mem_wdata_o and mem_wmask_o SHALL be held stable until mem_ready_i=1, then move to WAIT_RSP.
REQ-010 WAIT_RSP: mem_req_o=0. On mem_rvalid_i=1, SHALL capture mem_rdata_i and move to DONE. mem_rvalid_i SHALL be ignored in any other state.
REQ-011 DONE: wb_valid_o=1, with wb_data_o, wd_o, wreg_o, lsu_err_o stable until wb_ready_i=1, then move to IDLE.
REQ-012 Minimum latency, accept to wb_valid_o:
- pass-through or misaligned: 1 cycle
- memory op: 3 cycles when mem_ready_i and mem_rvalid_i each assert on their first eligible cycle
REQ-013 Store lanes:
- SB: mask 4'b0001<<addr[1:0], data {4{wdata[7:0]}}
- SH: mask 4'b0011<<addr[1:0], data {2{wdata[15:0]}}
- SW: mask 4'b1111, data wdata
REQ-014 Loads: mem_we_o=0, mask 4'b0000.
REQ-015 Load result:
- byte selected by addr[1:0]; halfword selected by addr[1]
- LB/LH sign-extended; LBU/LHU zero-extended; LW whole word
REQ-016 wb_data_o values:
- store: 0
- pass-through: registered addr_i
- misaligned: 0, with wd_o forced to 0
- otherwise: wd_o = registered wd_i
REQ-017 Back-to-back: a new op SHALL be accepted no earlier than the cycle after the DONE handshake.
REQ-018 mem_req_o SHALL never assert outside REQ.

Reset
REQ-019 Reset SHALL force IDLE. All outputs SHALL go to 0 except lsu_ready_o=1.
REQ-020 Reset in REQ or WAIT_RSP SHALL abandon the op with no write-back. A later stray mem_rvalid_i SHALL be ignored.

Verification
REQ-021 SW: addr=0x8000_0004, wdata=0xDEADBEEF, ready and rvalid immediate -> one request, we=1, mask 1111, addr 0x8000_0004; wb_valid 3 cycles after accept, wd_o=0.
REQ-022 LB: addr=0x8000_0003, rdata=0x80FF_1234 -> mask 0000, mem_addr 0x8000_0000, wb_data 0xFFFF_FF80; same access as LBU -> 0x0000_0080.
REQ-023 SH: addr=0x102, wdata=0x0000_ABCD -> mask 1100, mem_wdata 0xABCD_ABCD; mem_ready_i held low 4 cycles -> request fields stable all 4 cycles.
REQ-024 LW: addr=0x101 -> no mem_req_o; wb_valid 1 cycle after accept, lsu_err_o=1, wd_o=0, wb_data 0.
REQ-025 Pass-through: types none, addr=0x1234, wd=1, wreg=5, wb_ready low 3 cycles -> wb_data 0x1234, wreg 5 held; lsu_ready_o=0 until handshake.
REQ-026 Reset asserted in WAIT_RSP, then mem_rvalid_i pulsed -> IDLE, no wb_valid_o, lsu_ready_o=1.
